fir_xifu_ex: RTL



---
 rtl/fir_xifu_ex_if.sv | 25 ++
 rtl/fir_xifu_ex.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_ex_if.sv
// X-interface memory channel between the FIR execute stage and the memory unit.
// The request half and the result-return half are carried on the same bundle.
interface fir_xifu_ex_if #(
    parameter int ID_W = 4
);
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic [ID_W-1:0] mem_id;
    logic            mem_result_valid;
    logic [ID_W-1:0] mem_result_id;

    modport master (
        output mem_valid, mem_addr, mem_we, mem_be, mem_wdata, mem_id,
        input  mem_ready, mem_result_valid, mem_result_id
    );

    modport slave (
        input  mem_valid, mem_addr, mem_we, mem_be, mem_wdata, mem_id,
        output mem_ready, mem_result_valid, mem_result_id
    );
endinterface

// File: rtl/fir_xifu_ex.sv
// Execute stage of the FIR X-interface coprocessor: issues sample load/store requests,
// computes the circular post-increment address and queues writeback context until results return.
module fir_xifu_ex #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [1:0]        id_instr_i,
    input  logic [ID_W-1:0]   id_id_i,
    input  logic [31:0]       id_addr_i,
    input  logic [31:0]       id_wdata_i,
    input  logic [4:0]        id_rd_i,

    input  logic [31:0]       ctrl_stride_i,
    input  logic [31:0]       ctrl_buf_start_i,
    input  logic [31:0]       ctrl_buf_end_i,
    input  logic              ctrl_circ_en_i,

    fir_xifu_ex_if.master     mem,

    output logic              ex2wb_valid_o,
    output logic [1:0]        ex2wb_instr_o,
    output logic [31:0]       ex2wb_next_addr_o,
    output logic [4:0]        ex2wb_rd_o,
    output logic [ID_W-1:0]   ex2wb_id_o,
    output logic              err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_LDSAM = 2'd1;
    localparam logic [1:0] OP_STSAM = 2'd2;

    // state | meaning
    // IDLE  | waiting for a decoded instruction, ready while the queue has room
    // REQ   | memory request held on the channel until mem_ready
    typedef enum logic {IDLE, REQ} state_t;

    state_t state_q, state_d;

    logic             id_ready;
    logic             accept_mem;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             is_mem_op;

    logic [31:0]      sum;
    logic [31:0]      next_addr;

    logic [31:0]      req_addr_q;
    logic [31:0]      req_wdata_q;
    logic             req_we_q;
    logic [ID_W-1:0]  req_id_q;
    logic [1:0]       req_instr_q;
    logic [31:0]      req_next_addr_q;
    logic [4:0]       req_rd_q;

    logic [1:0]       fifo_instr     [DEPTH];
    logic [31:0]      fifo_next_addr [DEPTH];
    logic [4:0]       fifo_rd        [DEPTH];
    logic [ID_W-1:0]  fifo_id        [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_mem_op = (id_instr_i == OP_LDSAM) || (id_instr_i == OP_STSAM);
    assign fifo_full = (count_q == CNT_W'(DEPTH));

    // An unsigned compare against the exclusive end also catches sum == end.
    assign sum       = id_addr_i + ctrl_stride_i;
    assign next_addr = (ctrl_circ_en_i && (sum >= ctrl_buf_end_i))
                       ? (sum - ctrl_buf_end_i + ctrl_buf_start_i) : sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        id_ready   = 1'b0;
        accept_mem = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                id_ready = !fifo_full;
                if (id_valid_i && id_ready && is_mem_op) begin
                    accept_mem = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign id_ready_o = id_ready && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_we_q        <= 1'b0;
            req_id_q        <= '0;
            req_instr_q     <= '0;
            req_next_addr_q <= '0;
            req_rd_q        <= '0;
        end else if (accept_mem) begin
            req_addr_q      <= id_addr_i;
            req_wdata_q     <= id_wdata_i;
            req_we_q        <= (id_instr_i == OP_STSAM);
            req_id_q        <= id_id_i;
            req_instr_q     <= id_instr_i;
            req_next_addr_q <= next_addr;
            req_rd_q        <= id_rd_i;
        end
    end

    assign mem.mem_valid = (state_q == REQ);
    assign mem.mem_addr  = req_addr_q;
    assign mem.mem_we    = req_we_q;
    assign mem.mem_be    = 4'hF;
    assign mem.mem_wdata = req_wdata_q;
    assign mem.mem_id    = req_id_q;

    assign pop = mem.mem_result_valid && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i]     <= '0;
                fifo_next_addr[i] <= '0;
                fifo_rd[i]        <= '0;
                fifo_id[i]        <= '0;
            end
        end else begin
            if (push) begin
                fifo_instr[wr_ptr_q]     <= req_instr_q;
                fifo_next_addr[wr_ptr_q] <= req_next_addr_q;
                fifo_rd[wr_ptr_q]        <= req_rd_q;
                fifo_id[wr_ptr_q]        <= req_id_q;
                wr_ptr_q                 <= inc_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= inc_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ex2wb_valid_o     = (count_q != '0);
    assign ex2wb_instr_o     = fifo_instr[rd_ptr_q];
    assign ex2wb_next_addr_o = fifo_next_addr[rd_ptr_q];
    assign ex2wb_rd_o        = fifo_rd[rd_ptr_q];
    assign ex2wb_id_o        = fifo_id[rd_ptr_q];

    // A mismatched id still pops so the queue stays aligned with the memory stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (mem.mem_result_valid &&
                     ((count_q == '0) || (mem.mem_result_id != ex2wb_id_o))) begin
            err_o <= 1'b1;
        end
    end

endmodule
